// File: rtl/axi_wr_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_wr_slave_pkg
//  Description : Shared types and helpers for the AXI4 write-channel responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_wr_slave_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_DATA = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // WRAP bursts must be 2, 4, 8 or 16 beats long.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_wr_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_wr_slave_if
//  Description : AXI4 AW/W/B channel bundle with master and slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_wr_slave_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID, BREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID
    );

endinterface
`default_nettype wire

// File: rtl/axi_wr_slave_burst_addr.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_addr
//  Description : Combinational next-beat address and illegal-burst detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr
    import axi_wr_slave_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int STRB_W = 4
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [7:0]        len_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              illegal_o
);
    localparam int LG_STRB = $clog2(STRB_W);

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_base;

    always_comb begin
        w_step = ADDR_W'(1) << size_i;
        w_mask = (ADDR_W'(9'(len_i) + 9'd1) << size_i) - ADDR_W'(1);
        w_base = addr_i & ~w_mask;

        next_addr_o = addr_i;
        case (burst_i)
            BURST_INCR: next_addr_o = addr_i + w_step;
            BURST_WRAP: next_addr_o = w_base | ((addr_i + w_step) & w_mask);
            default:    next_addr_o = addr_i;
        endcase

        illegal_o = (size_i > 3'(LG_STRB)) || (burst_i == 2'b11) ||
                    ((burst_i == BURST_WRAP) &&
                     (!wrap_len_ok(len_i) || ((addr_i & (w_step - ADDR_W'(1))) != '0)));
    end

endmodule
`default_nettype wire

// File: rtl/axi_wr_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_wr_slave
//  Description : AXI4 write responder terminating one burst at a time into a
//                byte-strobed word memory with a combinational backdoor read.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_slave
    import axi_wr_slave_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256,
    localparam int STRB_W   = DATA_W / 8,
    localparam int DBG_W    = $clog2(MEM_DEPTH)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi_wr_slave_if.slave     axi,
    input  logic [DBG_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int LG_STRB = $clog2(STRB_W);

    state_e            state_q, state_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    resp_e             bresp_q, bresp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic              err_q, err_d;
    logic              ill_q, ill_d;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic              w_aw_hs, w_w_hs, w_b_hs;
    logic              w_last_beat, w_in_range, w_beat_err;
    logic [ADDR_W-1:0] w_word_idx;
    logic [ADDR_W-1:0] w_ba_addr, w_ba_next;
    logic [2:0]        w_ba_size;
    logic [7:0]        w_ba_len;
    logic [1:0]        w_ba_burst;
    logic              w_ba_illegal;

    assign w_aw_hs     = axi.AWVALID && awready_q;
    assign w_w_hs      = axi.WVALID && wready_q;
    assign w_b_hs      = bvalid_q && axi.BREADY;
    assign w_last_beat = (cnt_q == len_q);
    assign w_word_idx  = addr_q >> LG_STRB;
    assign w_in_range  = (int'(w_word_idx) < MEM_DEPTH);
    assign w_beat_err  = (axi.WLAST != w_last_beat) || !w_in_range;

    // In IDLE the calculator checks the incoming AW; afterwards it steps the latched burst.
    assign w_ba_addr  = (state_q == S_IDLE) ? axi.AWADDR  : addr_q;
    assign w_ba_size  = (state_q == S_IDLE) ? axi.AWSIZE  : size_q;
    assign w_ba_len   = (state_q == S_IDLE) ? axi.AWLEN   : len_q;
    assign w_ba_burst = (state_q == S_IDLE) ? axi.AWBURST : burst_q;

    axi_burst_addr #(
        .ADDR_W (ADDR_W),
        .STRB_W (STRB_W)
    ) u_burst_addr (
        .addr_i      (w_ba_addr),
        .size_i      (w_ba_size),
        .len_i       (w_ba_len),
        .burst_i     (w_ba_burst),
        .next_addr_o (w_ba_next),
        .illegal_o   (w_ba_illegal)
    );

    always_comb begin
        state_d = state_q;
        bid_d   = bid_q;
        bresp_d = bresp_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        burst_d = burst_q;
        err_d   = err_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: begin
                if (w_aw_hs) begin
                    state_d = S_DATA;
                    bid_d   = axi.AWID;
                    addr_d  = axi.AWADDR;
                    len_d   = axi.AWLEN;
                    size_d  = axi.AWSIZE;
                    burst_d = axi.AWBURST;
                    cnt_d   = 8'd0;
                    err_d   = w_ba_illegal;
                    ill_d   = w_ba_illegal;
                end
            end
            S_DATA: begin
                if (w_w_hs) begin
                    cnt_d  = cnt_q + 8'd1;
                    addr_d = w_ba_next;
                    err_d  = err_q || w_beat_err;
                    if (w_last_beat) begin
                        state_d = S_RESP;
                        bresp_d = (err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            S_RESP: begin
                if (w_b_hs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        awready_d = (state_d == S_IDLE);
        wready_d  = (state_d == S_DATA);
        bvalid_d  = (state_d == S_RESP);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'b00;
            err_q     <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            ill_q     <= ill_d;
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge ACLK) begin
        if (ARESETn && w_w_hs && !ill_q && w_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi.WSTRB[b]) mem_q[w_word_idx[DBG_W-1:0]][b*8 +: 8] <= axi.WDATA[b*8 +: 8];
            end
        end
    end

    assign dbg_data    = mem_q[dbg_addr];
    assign axi.AWREADY = awready_q;
    assign axi.WREADY  = wready_q;
    assign axi.BVALID  = bvalid_q;
    assign axi.BID     = bid_q;
    assign axi.BRESP   = bresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_wr_slave
//  Description : Directed table-driven bench for the AXI4 write responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_wr_slave;
    localparam int ID_W      = 4;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 256;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    axi_wr_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_wr_slave #(
        .ID_W      (ID_W),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .ACLK     (clk),
        .ARESETn  (rstn),
        .axi      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    typedef struct {
        logic [3:0]       id;
        logic [11:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        int               bad_beat;
        logic [3:0][31:0] data;
        logic [3:0][3:0]  strb;
        int               bwait;
        logic [1:0]       resp;
        int               chk_n;
        logic [3:0][7:0]  chk_idx;
        logic [3:0][31:0] chk_val;
    } vec_t;

    vec_t vecs[12];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [7:0] idx, input logic [31:0] val);
        dbg_addr = idx;
        #1;
        check(name, dbg_data, val);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int n;
        @(negedge clk);
        bus.AWID    = v.id;
        bus.AWADDR  = v.addr;
        bus.AWLEN   = v.len;
        bus.AWSIZE  = v.size;
        bus.AWBURST = v.burst;
        bus.AWVALID = 1'b1;
        n = 0;
        while (!bus.AWREADY && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d awready", k), bus.AWREADY, 1);
        @(negedge clk);
        bus.AWVALID = 1'b0;
        for (int b = 0; b <= int'(v.len); b++) begin
            bus.WVALID = 1'b1;
            bus.WDATA  = v.data[b];
            bus.WSTRB  = v.strb[b];
            bus.WLAST  = (v.bad_beat >= 0) ? (b == v.bad_beat) : (b == int'(v.len));
            check($sformatf("v%0d wready beat%0d", k, b), bus.WREADY, 1);
            @(negedge clk);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        check($sformatf("v%0d bvalid latency", k), bus.BVALID, 1);
        check($sformatf("v%0d bresp", k), bus.BRESP, v.resp);
        check($sformatf("v%0d bid", k), bus.BID, v.id);
        for (int w = 0; w < v.bwait; w++) begin
            @(negedge clk);
            check($sformatf("v%0d bvalid hold%0d", k, w), bus.BVALID, 1);
            check($sformatf("v%0d bresp hold%0d", k, w), bus.BRESP, v.resp);
            check($sformatf("v%0d bid hold%0d", k, w), bus.BID, v.id);
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        check($sformatf("v%0d bvalid drop", k), bus.BVALID, 0);
        check($sformatf("v%0d awready after b", k), bus.AWREADY, 1);
        for (int i = 0; i < v.chk_n; i++) begin
            check_word($sformatf("v%0d mem[%0d]", k, v.chk_idx[i]), v.chk_idx[i], v.chk_val[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b0; dbg_addr = 8'd0;

        vecs[0]  = '{4'h3, 12'h010, 8'd3, 3'd2, 2'b01, -1, {32'd4, 32'd3, 32'd2, 32'd1}, 16'hFFFF, 0, 2'b00,
                     4, {8'd7, 8'd6, 8'd5, 8'd4}, {32'd4, 32'd3, 32'd2, 32'd1}};
        vecs[1]  = '{4'hA, 12'h038, 8'd3, 3'd2, 2'b10, -1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'hFFFF, 0, 2'b00,
                     4, {8'd13, 8'd12, 8'd15, 8'd14}, {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[2]  = '{4'h1, 12'h020, 8'd0, 3'd2, 2'b01, -1, {96'h0, 32'hDDCCBBAA}, 16'h000F, 0, 2'b00,
                     1, {24'h0, 8'd8}, {96'h0, 32'hDDCCBBAA}};
        vecs[3]  = '{4'h2, 12'h020, 8'd2, 3'd2, 2'b00, -1, {32'h0, 32'h33333333, 32'h22222222, 32'h11111111},
                     16'h0421, 0, 2'b00, 1, {24'h0, 8'd8}, {96'h0, 32'hDD332211}};
        vecs[4]  = '{4'h5, 12'h040, 8'd1, 3'd2, 2'b01, -1, {64'h0, 32'h12345678, 32'h5555AAAA}, 16'h00FF, 0, 2'b00,
                     2, {16'h0, 8'd17, 8'd16}, {64'h0, 32'h12345678, 32'h5555AAAA}};
        vecs[5]  = '{4'h6, 12'h040, 8'd1, 3'd3, 2'b01, -1, {64'h0, 32'hFFFFFFFF, 32'hFFFFFFFF}, 16'h00FF, 0, 2'b10,
                     2, {16'h0, 8'd17, 8'd16}, {64'h0, 32'h12345678, 32'h5555AAAA}};
        vecs[6]  = '{4'h7, 12'h080, 8'd3, 3'd2, 2'b01, 1, {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 16'hFFFF, 5, 2'b10,
                     4, {8'd35, 8'd34, 8'd33, 8'd32}, {32'hC4, 32'hC3, 32'hC2, 32'hC1}};
        vecs[7]  = '{4'h8, 12'h3FC, 8'd1, 3'd2, 2'b01, -1, {64'h0, 32'hE2, 32'hE1}, 16'h00FF, 0, 2'b10,
                     1, {24'h0, 8'd255}, {96'h0, 32'hE1}};
        vecs[8]  = '{4'h9, 12'h040, 8'd0, 3'd2, 2'b11, -1, {96'h0, 32'hFFFFFFFF}, 16'h000F, 0, 2'b10,
                     1, {24'h0, 8'd16}, {96'h0, 32'h5555AAAA}};
        vecs[9]  = '{4'hB, 12'h040, 8'd2, 3'd2, 2'b10, -1, {32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                     16'h0FFF, 0, 2'b10, 2, {16'h0, 8'd17, 8'd16}, {64'h0, 32'h12345678, 32'h5555AAAA}};
        vecs[10] = '{4'hC, 12'h042, 8'd1, 3'd2, 2'b10, -1, {64'h0, 32'hFFFFFFFF, 32'hFFFFFFFF}, 16'h00FF, 0, 2'b10,
                     2, {16'h0, 8'd17, 8'd16}, {64'h0, 32'h12345678, 32'h5555AAAA}};
        vecs[11] = '{4'hD, 12'h046, 8'd3, 3'd1, 2'b10, -1, {32'h00009999, 32'h12340000, 32'h0000CAFE, 32'hBEEF0000},
                     16'h3C3C, 2, 2'b00, 2, {16'h0, 8'd17, 8'd16}, {64'h0, 32'hBEEF9999, 32'h1234CAFE}};

        repeat (3) @(negedge clk);
        check("reset awready", bus.AWREADY, 0);
        check("reset wready", bus.WREADY, 0);
        check("reset bvalid", bus.BVALID, 0);
        check("reset bid", bus.BID, 0);
        check("reset bresp", bus.BRESP, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("awready after release", bus.AWREADY, 1);

        // W beats offered before any AW must be held off.
        bus.WVALID = 1'b1;
        bus.WLAST  = 1'b1;
        bus.WDATA  = 32'hBADBAD00;
        bus.WSTRB  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle wready%0d", i), bus.WREADY, 0);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;

        for (int k = 0; k < 12; k++) run_vec(vecs[k], k);

        // Reset after two of four beats: burst abandoned, written beats kept.
        @(negedge clk);
        bus.AWID = 4'h4; bus.AWADDR = 12'h100; bus.AWLEN = 8'd3; bus.AWSIZE = 3'd2;
        bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
        check("rst-burst awready", bus.AWREADY, 1);
        @(negedge clk);
        bus.AWVALID = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.WVALID = 1'b1;
            bus.WDATA  = 32'h71 + 32'(b);
            bus.WSTRB  = 4'hF;
            bus.WLAST  = 1'b0;
            check($sformatf("rst-burst wready%0d", b), bus.WREADY, 1);
            @(negedge clk);
        end
        bus.WVALID = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        check("mid-rst awready", bus.AWREADY, 0);
        check("mid-rst wready", bus.WREADY, 0);
        check("mid-rst bvalid", bus.BVALID, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("post-rst awready", bus.AWREADY, 1);
        check("post-rst wready", bus.WREADY, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post-rst no bvalid%0d", i), bus.BVALID, 0);
        end
        check_word("rst-burst mem[64]", 8'd64, 32'h71);
        check_word("rst-burst mem[65]", 8'd65, 32'h72);

        run_vec(vecs[0], 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
